dmem_access_ctrl: RTL

- Sequences data-memory accesses from the MEM stage onto the SRAM-like data bus (req/addr_ok/data_ok) and stalls the pipeline until each access completes.
- Sits between the MEM stage outputs (mem_en, byte write enables, address, write data) and the data-bus master port.
- Captures load data for the writeback path.
- Handles flushes while a transaction is outstanding, so the bus never sees a withdrawn request or an orphaned response.

---
 rtl/dmem_access_ctrl_if.sv | 32 +++
 rtl/dmem_access_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Data-bus interface between the data-memory access controller (master) and
// the SRAM-like data bus slave.
//   req      master -> slave  request valid, held until addr_ok
//   wr       master -> slave  1 = write
//   size     master -> slave  0 = byte, 1 = half, 2 = word
//   addr     master -> slave  byte address
//   wdata    master -> slave  byte-lane-aligned write data
//   wstrb    master -> slave  byte strobes
//   addr_ok  slave -> master  request accepted
//   data_ok  slave -> master  read data valid / write complete
//   rdata    slave -> master  read data
interface dmem_access_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata, wstrb,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata, wstrb,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller. Turns a MEM-stage access into a single
// transaction on the SRAM-like data bus, stalls the pipeline until it
// completes, and captures load data for writeback. A flush while a
// transaction is outstanding never withdraws a request and always consumes
// the matching response.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_en_i        MEM-stage access valid (already exception-masked)
//   mem_wen_i       byte write enables, 0000 = load
//   mem_size_i      load size: 0 byte, 1 half, 2 word
//   mem_addr_i      access address
//   mem_wdata_i     lane-aligned store data
//   flush_i         pipeline flush
//   pipe_stall_i    MEM stage held by another source
//   stall_o         hold MEM stage and upstream
//   rdata_o         captured load data
//   rdata_valid_o   rdata_o / access result valid for current MEM instruction
//   data_bus        data-bus master port
//
// state  | meaning
// IDLE   | no access in flight; latch fields when an access arrives
// REQ    | data_req_o high, waiting for addr_ok
// WAIT   | request accepted, waiting for data_ok
// DONE   | access complete, pipeline released, waiting for MEM to advance
// DRAIN  | access was flushed; swallow its response
module dmem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic [3:0]  mem_wen_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    input  logic        pipe_stall_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    dmem_access_ctrl_if.master data_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state;
    logic        kill;
    logic        req_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;

    logic [1:0]  enc_size;
    logic [1:0]  enc_addr_lo;

    // Stores derive size and low address bits from the strobe pattern so
    // partial-word stores (swl/swr style) go out as aligned word writes.
    always_comb begin
        enc_size    = 2'd2;
        enc_addr_lo = 2'b00;
        case (mem_wen_i)
            4'b0000: begin
                enc_size    = mem_size_i;
                enc_addr_lo = mem_addr_i[1:0];
            end
            4'b0001: begin enc_size = 2'd0; enc_addr_lo = 2'b00; end
            4'b0010: begin enc_size = 2'd0; enc_addr_lo = 2'b01; end
            4'b0100: begin enc_size = 2'd0; enc_addr_lo = 2'b10; end
            4'b1000: begin enc_size = 2'd0; enc_addr_lo = 2'b11; end
            4'b0011: begin enc_size = 2'd1; enc_addr_lo = 2'b00; end
            4'b1100: begin enc_size = 2'd1; enc_addr_lo = 2'b10; end
            default: begin enc_size = 2'd2; enc_addr_lo = 2'b00; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            kill     <= 1'b0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_en_i && !flush_i) begin
                        wr_q    <= |mem_wen_i;
                        size_q  <= enc_size;
                        addr_q  <= {mem_addr_i[31:2], enc_addr_lo};
                        wdata_q <= mem_wdata_i;
                        wstrb_q <= mem_wen_i;
                        req_q   <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A flush cannot retract the request; remember it and
                    // drain the response once the slave has accepted.
                    kill <= kill | flush_i;
                    if (data_bus.addr_ok) begin
                        req_q <= 1'b0;
                        state <= (kill || flush_i) ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_bus.data_ok) begin
                        if (flush_i) begin
                            state <= S_IDLE;
                        end else begin
                            if (!wr_q) begin
                                rdata_q <= data_bus.rdata;
                            end
                            rvalid_q <= 1'b1;
                            state    <= S_DONE;
                        end
                    end else if (flush_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (!pipe_stall_i || flush_i) begin
                        rvalid_q <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (data_bus.data_ok) begin
                        kill  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    req_q    <= 1'b0;
                    rvalid_q <= 1'b0;
                    kill     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // The IDLE term stalls in the same cycle the access is first seen, so the
    // MEM instruction cannot slip past before its request has issued.
    assign stall_o = (state == S_IDLE && mem_en_i && !flush_i) ||
                     (state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN);

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;

    assign data_bus.req   = req_q;
    assign data_bus.wr    = wr_q;
    assign data_bus.size  = size_q;
    assign data_bus.addr  = addr_q;
    assign data_bus.wdata = wdata_q;
    assign data_bus.wstrb = wstrb_q;

endmodule
